// File: rtl/uart_tx_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_sched_if
//  Description : Requester-side byte streams and TX FIFO write port shared
//                by the UART transmit scheduler.
//  Revision    : 1.0  initial release
// ============================================================================
interface uart_tx_sched_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 tx_full;
  logic                 tx_wr_en;
  logic [7:0]           tx_data;
  logic [NUM_REQ-1:0]   grant;
  logic                 busy;

  // Requesters and FIFO side
  modport master (
    output req_valid, req_data, req_last, tx_full,
    input  req_ready, tx_wr_en, tx_data, grant, busy
  );

  // Scheduler side
  modport slave (
    input  req_valid, req_data, req_last, tx_full,
    output req_ready, tx_wr_en, tx_data, grant, busy
  );
endinterface
`default_nettype wire

// File: rtl/uart_tx_sched.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_sched
//  Description : Round-robin scheduler sharing one UART TX FIFO write port
//                between NUM_REQ byte-stream requesters, with optional
//                channel-ID header, burst limit and stall timeout.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_tx_sched #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 8,
  parameter int HDR_EN    = 1,
  parameter int STALL_MAX = 64
) (
  input  logic           clk,
  input  logic           reset,
  uart_tx_sched_if.slave bus
);

  localparam int c_idx_w   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int c_stall_w = (STALL_MAX > 1) ? $clog2(STALL_MAX) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t               r_state,     w_state_nx;
  logic [NUM_REQ-1:0]   r_grant,     w_grant_nx;
  logic [c_idx_w-1:0]   r_idx,       w_idx_nx;
  logic [c_idx_w-1:0]   r_last_idx,  w_last_idx_nx;
  logic [7:0]           r_burst_cnt, w_burst_cnt_nx;
  logic [c_stall_w-1:0] r_stall_cnt, w_stall_cnt_nx;

  logic                 w_pick_any;
  logic [c_idx_w-1:0]   w_pick_idx;
  logic [c_idx_w-1:0]   w_cand;
  logic                 w_sel_valid;
  logic [7:0]           w_sel_data;
  logic                 w_sel_last;
  logic                 w_fire;
  logic                 w_tx_wr_en;
  logic [7:0]           w_tx_data;
  logic [NUM_REQ-1:0]   w_req_ready;

  // Round-robin pick: walk downward so the candidate nearest last+1 wins.
  always_comb begin
    w_pick_any = 1'b0;
    w_pick_idx = '0;
    w_cand     = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_cand = c_idx_w'((int'(r_last_idx) + k) % NUM_REQ);
      if (bus.req_valid[w_cand]) begin
        w_pick_any = 1'b1;
        w_pick_idx = w_cand;
      end
    end
  end

  assign w_sel_valid = bus.req_valid[r_idx];
  assign w_sel_data  = bus.req_data[{r_idx, 3'b000} +: 8];
  assign w_sel_last  = bus.req_last[r_idx];
  assign w_fire      = w_sel_valid & ~bus.tx_full;

  // Next-state, counters and the zero-latency FIFO write path.
  always_comb begin
    w_state_nx     = r_state;
    w_grant_nx     = r_grant;
    w_idx_nx       = r_idx;
    w_last_idx_nx  = r_last_idx;
    w_burst_cnt_nx = r_burst_cnt;
    w_stall_cnt_nx = r_stall_cnt;
    w_tx_wr_en     = 1'b0;
    w_tx_data      = 8'h00;
    w_req_ready    = '0;

    case (r_state)
      IDLE: begin
        if (w_pick_any) begin
          w_grant_nx             = '0;
          w_grant_nx[w_pick_idx] = 1'b1;
          w_idx_nx               = w_pick_idx;
          w_burst_cnt_nx         = 8'd0;
          w_stall_cnt_nx         = '0;
          w_state_nx             = (HDR_EN != 0) ? HDR : DATA;
        end
      end

      HDR: begin
        if (!bus.tx_full) begin
          w_tx_wr_en = 1'b1;
          w_tx_data  = {4'hA, 4'(r_idx)};
          w_state_nx = DATA;
        end
      end

      DATA: begin
        w_req_ready[r_idx] = ~bus.tx_full;
        if (w_fire) begin
          w_tx_wr_en     = 1'b1;
          w_tx_data      = w_sel_data;
          w_burst_cnt_nx = r_burst_cnt + 8'd1;
          w_stall_cnt_nx = '0;
          if (w_sel_last || (r_burst_cnt == 8'(MAX_BURST - 1))) begin
            w_state_nx    = IDLE;
            w_last_idx_nx = r_idx;
            w_grant_nx    = '0;
          end
        end else if (!bus.tx_full) begin
          // Requester went quiet while the FIFO could have taken a byte.
          if (r_stall_cnt == c_stall_w'(STALL_MAX - 1)) begin
            w_state_nx    = IDLE;
            w_last_idx_nx = r_idx;
            w_grant_nx    = '0;
          end else begin
            w_stall_cnt_nx = r_stall_cnt + 1'b1;
          end
        end
      end

      default: w_state_nx = IDLE;
    endcase

    // Nothing leaves the block while reset is held.
    if (reset) begin
      w_tx_wr_en  = 1'b0;
      w_tx_data   = 8'h00;
      w_req_ready = '0;
    end
  end

  // State register; reset restarts arbitration at requester 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_grant     <= '0;
      r_idx       <= '0;
      r_last_idx  <= c_idx_w'(NUM_REQ - 1);
      r_burst_cnt <= 8'd0;
      r_stall_cnt <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_grant     <= w_grant_nx;
      r_idx       <= w_idx_nx;
      r_last_idx  <= w_last_idx_nx;
      r_burst_cnt <= w_burst_cnt_nx;
      r_stall_cnt <= w_stall_cnt_nx;
    end
  end

  assign bus.tx_wr_en  = w_tx_wr_en;
  assign bus.tx_data   = w_tx_data;
  assign bus.req_ready = w_req_ready;
  assign bus.grant     = r_grant;
  assign bus.busy      = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_sched
//  Description : Self-checking bench for uart_tx_sched; expected FIFO bytes
//                are queued when stimulus is loaded and popped on each write.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_tx_sched;

  logic clk;
  logic reset;

  uart_tx_sched_if #(.NUM_REQ(4)) bus ();

  uart_tx_sched #(
    .NUM_REQ  (4),
    .MAX_BURST(8),
    .HDR_EN   (1),
    .STALL_MAX(64)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests;
  int n_fail;
  int wr_count;

  // Requester models: {last, data} per entry, read pointer advances on accept.
  logic [8:0] src_mem [4][32];
  int         src_rd  [4];
  int         src_wr  [4];

  logic [7:0] sb [$];

  logic [3:0] s_grant;
  logic       s_busy;
  logic       s_wr;
  logic [7:0] s_data;
  logic [3:0] s_ready;
  logic [7:0] exp_b;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic load(input int ch, input logic [7:0] d, input logic last);
    src_mem[ch][src_wr[ch]] = {last, d};
    src_wr[ch]++;
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < 4; i++) begin
      if (src_rd[i] < src_wr[i]) begin
        bus.req_valid[i]        = 1'b1;
        bus.req_data[8*i +: 8]  = src_mem[i][src_rd[i]][7:0];
        bus.req_last[i]         = src_mem[i][src_rd[i]][8];
      end else begin
        bus.req_valid[i]        = 1'b0;
        bus.req_data[8*i +: 8]  = 8'h00;
        bus.req_last[i]         = 1'b0;
      end
    end
  endtask

  task automatic sample_outputs();
    s_grant = bus.grant;
    s_busy  = bus.busy;
    s_wr    = bus.tx_wr_en;
    s_data  = bus.tx_data;
    s_ready = bus.req_ready;
    check_eq("ready_outside_grant", 32'(s_ready & ~s_grant), 32'd0);
    if (bus.tx_full) begin
      check_eq("wr_while_full", 32'(s_wr), 32'd0);
      check_eq("ready_while_full", 32'(s_ready), 32'd0);
    end
    if (s_wr) begin
      wr_count++;
      if (sb.size() == 0) begin
        check_eq("unexpected_write", 32'(s_data), 32'h1FF);
      end else begin
        exp_b = sb.pop_front();
        check_eq("tx_data", 32'(s_data), 32'(exp_b));
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (bus.req_valid[i] && s_ready[i]) src_rd[i]++;
    end
  endtask

  task automatic cycle();
    drive_inputs();
    @(negedge clk);
    sample_outputs();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    bus.tx_full = 1'b0;
    for (int i = 0; i < 4; i++) begin
      src_rd[i] = 0;
      src_wr[i] = 0;
    end
    sb.delete();
    cycle();
    cycle();
    check_eq("rst_grant", 32'(s_grant), 32'd0);
    check_eq("rst_busy", 32'(s_busy), 32'd0);
    check_eq("rst_wr", 32'(s_wr), 32'd0);
    check_eq("rst_data", 32'(s_data), 32'd0);
    check_eq("rst_ready", 32'(s_ready), 32'd0);
    reset    = 1'b0;
    wr_count = 0;
  endtask

  task automatic run_until_wr(input int n, input string tag);
    int k;
    for (k = 0; k < 100; k++) begin
      if (wr_count >= n) break;
      cycle();
    end
    check_eq({tag, "_wr_timeout"}, 32'(wr_count >= n), 32'd1);
  endtask

  task automatic wait_done(input string tag);
    logic done;
    done = 1'b0;
    for (int k = 0; k < 400; k++) begin
      cycle();
      if (sb.size() == 0 && !s_busy) begin
        done = 1'b1;
        break;
      end
    end
    check_eq({tag, "_done_timeout"}, 32'(done), 32'd1);
    check_eq({tag, "_sb_left"}, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int n;
    n_tests       = 0;
    n_fail        = 0;
    wr_count      = 0;
    reset         = 1'b1;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    bus.tx_full   = 1'b0;

    // Single byte on ch0: IDLE, header A0, data 55, back to idle.
    do_reset();
    load(0, 8'h55, 1'b1);
    sb.push_back(8'hA0);
    sb.push_back(8'h55);
    cycle();
    check_eq("t1_grant_idle", 32'(s_grant), 32'd0);
    cycle();
    check_eq("t1_grant_hdr", 32'(s_grant), 32'b0001);
    check_eq("t1_busy_hdr", 32'(s_busy), 32'd1);
    check_eq("t1_wr_hdr", 32'(s_wr), 32'd1);
    cycle();
    check_eq("t1_grant_data", 32'(s_grant), 32'b0001);
    check_eq("t1_wr_data", 32'(s_wr), 32'd1);
    cycle();
    check_eq("t1_busy_end", 32'(s_busy), 32'd0);
    check_eq("t1_grant_end", 32'(s_grant), 32'd0);
    check_eq("t1_sb_left", 32'(sb.size()), 32'd0);

    // Four requesters, single-byte messages: strict rotation 0,1,2,3,0.
    do_reset();
    load(0, 8'h10, 1'b1);
    load(0, 8'h14, 1'b1);
    load(1, 8'h11, 1'b1);
    load(2, 8'h12, 1'b1);
    load(3, 8'h13, 1'b1);
    sb.push_back(8'hA0); sb.push_back(8'h10);
    sb.push_back(8'hA1); sb.push_back(8'h11);
    sb.push_back(8'hA2); sb.push_back(8'h12);
    sb.push_back(8'hA3); sb.push_back(8'h13);
    sb.push_back(8'hA0); sb.push_back(8'h14);
    wait_done("t2");

    // ch2 streams 20 bytes without last: split into 8 + 8 + 4, then stall out.
    do_reset();
    for (int b = 0; b < 20; b++) begin
      load(2, 8'(b), 1'b0);
      if (b % 8 == 0) sb.push_back(8'hA2);
      sb.push_back(8'(b));
    end
    wait_done("t3");

    // FIFO full for 5 cycles mid-burst: no writes, no ready, no loss.
    do_reset();
    for (int b = 0; b < 6; b++) load(1, 8'h20 + 8'(b), (b == 5));
    sb.push_back(8'hA1);
    for (int b = 0; b < 6; b++) sb.push_back(8'h20 + 8'(b));
    run_until_wr(3, "t4");
    bus.tx_full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cycle();
      check_eq("t4_full_busy", 32'(s_busy), 32'd1);
    end
    bus.tx_full = 1'b0;
    wait_done("t4");

    // ch1 goes quiet after 2 bytes: released after 64 stall cycles, ch3 next.
    do_reset();
    load(1, 8'h30, 1'b0);
    load(1, 8'h31, 1'b0);
    load(3, 8'h40, 1'b1);
    sb.push_back(8'hA1); sb.push_back(8'h30); sb.push_back(8'h31);
    sb.push_back(8'hA3); sb.push_back(8'h40);
    run_until_wr(3, "t5");
    check_eq("t5_grant_ch1", 32'(s_grant), 32'b0010);
    n = 0;
    for (int k = 0; k < 200; k++) begin
      cycle();
      if (s_grant == 4'b0000) break;
      n++;
    end
    check_eq("t5_stall_len", 32'(n), 32'd64);
    cycle();
    check_eq("t5_grant_ch3", 32'(s_grant), 32'b1000);
    wait_done("t5");

    // Reset mid-burst on ch3: burst abandoned, arbitration restarts at ch0.
    do_reset();
    for (int b = 0; b < 6; b++) load(3, 8'h50 + 8'(b), (b == 5));
    sb.push_back(8'hA3); sb.push_back(8'h50); sb.push_back(8'h51);
    run_until_wr(3, "t6");
    reset = 1'b1;
    load(2, 8'h60, 1'b1);
    cycle();
    check_eq("t6_rst_wr", 32'(s_wr), 32'd0);
    check_eq("t6_rst_ready", 32'(s_ready), 32'd0);
    check_eq("t6_rst_data", 32'(s_data), 32'd0);
    reset = 1'b0;
    cycle();
    check_eq("t6_post_grant", 32'(s_grant), 32'd0);
    check_eq("t6_post_busy", 32'(s_busy), 32'd0);
    check_eq("t6_post_wr", 32'(s_wr), 32'd0);
    check_eq("t6_sb_trunc", 32'(sb.size()), 32'd0);
    sb.push_back(8'hA2); sb.push_back(8'h60);
    sb.push_back(8'hA3);
    for (int b = 2; b < 6; b++) sb.push_back(8'h50 + 8'(b));
    cycle();
    check_eq("t6_grant_ch2", 32'(s_grant), 32'b0100);
    wait_done("t6");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
